puf_crp_sequencer: RTL
======================

// Module: puf_crp_sequencer
// PURPOSE
//   Sequences one full challenge-response evaluation of the arbiter PUF on GPIO_0.
//   On start it latches a 64-bit seed challenge and applies it to the PUF.
//   For each response bit it pulses excite, waits a settle window, samples the arbiter output and steps an LFSR to the next challenge.
//   It sits between the board-level controller (KEY/SW/HEX) and the PUF pins, and hands the packed response to the display/UART path.
// PARAMETERS
//   RESP_BITS      64  response bits collected per run (1..64)
//   SETTLE_CYCLES  4   clk cycles between excite pulse and sample (>=1)
// PORTS
//   clk            in   1   system clock, all state on rising edge
//   rst            in   1   asynchronous, active-high reset
//   start          in   1   single-cycle run request, honoured only in IDLE
//   challenge_in   in   64  seed challenge, sampled with start
//   puf_resp       in   1   arbiter output, already synchronised by the caller
//   puf_challenge  out  64  challenge applied to the PUF delay lines (registered)
//   puf_excite     out  1   one-cycle launch pulse into both PUF paths
//   busy           out  1   high from the cycle after start until DONE exits
//   done           out  1   one-cycle pulse when response is valid
//   response       out  64  packed response, MSB = first bit sampled, held until next start
//   bit_count      out  7   bits sampled so far in current run
// BEHAVIOUR
//   Reset: state=IDLE; puf_challenge, response, bit_count = 0; puf_excite, busy, done = 0.
//   Reset mid-run aborts at once: no done pulse, partial response discarded (cleared to 0).
//   FSM states IDLE -> APPLY -> SETTLE -> SAMPLE -> (APPLY | DONE) -> IDLE.
//   IDLE: start=1 -> latch seed into puf_challenge, clear response and bit_count -> APPLY.
//     Zero seed is replaced by 64'h1 so the LFSR cannot lock.
//   APPLY: puf_excite=1 for exactly this cycle -> SETTLE.
//   SETTLE: count SETTLE_CYCLES cycles with puf_excite=0 -> SAMPLE.
//   SAMPLE: response <= {response[62:0], resp_bit}; bit_count++.
//     puf_challenge steps the Fibonacci LFSR: taps 64,63,61,60; shift left, XOR into bit0.
//     If bit_count == RESP_BITS-1 -> DONE, else -> APPLY.
//   DONE: done=1, busy=0 this cycle -> IDLE. puf_challenge keeps its last value.
//   Latency: done asserts RESP_BITS*(SETTLE_CYCLES+2)+1 cycles after start is sampled.
//     With the defaults this is 385 cycles.
//   start while busy (including in DONE) is ignored; it is not queued.
//   For RESP_BITS<64 the upper response bits are 0; bits are right-aligned.
// CONFIGURATION
//   PUF_MAJORITY_VOTE_EN defined:
//     each challenge is evaluated 3 times (APPLY/SETTLE/SAMPLE x3, same challenge).
//     A 2-bit vote counter accumulates puf_resp; resp_bit = (votes >= 2).
//     LFSR steps and bit_count increments only after the third sample.
//     Latency becomes RESP_BITS*3*(SETTLE_CYCLES+2)+1.
//   Not defined: single evaluation per bit, resp_bit = puf_resp.
// STRUCTURE
//   Package puf_pkg: state enum (IDLE/APPLY/SETTLE/SAMPLE/DONE), LFSR tap mask constant,
//     PUF_CHAL_W=64, zero-seed substitute constant.
//   Sub-module puf_chal_lfsr: 64-bit register with load (seed, zero-substitute) and step enables.
//     It drives puf_challenge.
//   The FSM, settle counter, vote counter and response shifter stay in this module.
// TESTING
//   Stub PUF puf_resp=1; start with challenge_in=64'hA5A5_A5A5_A5A5_A5A5
//     -> done at cycle 385, response=64'hFFFF_FFFF_FFFF_FFFF, 64 excite pulses.
//   Stub puf_resp=^puf_challenge, seed 64'h1
//     -> response matches a bench LFSR/parity model bit-for-bit; first puf_challenge=64'h1.
//   challenge_in=0 -> puf_challenge=64'h1 in APPLY; second challenge=64'h2.
//   rst pulsed when bit_count=10 -> next edge: busy=0, response=0, bit_count=0, no done.
//   start held high for 400 cycles -> exactly one done pulse per run; a new run begins only from IDLE.
//   PUF_MAJORITY_VOTE_EN, puf_resp pattern 1,0,1 per bit -> response all ones, done at cycle 1153.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared types and constants for the arbiter-PUF challenge/response sequencer.
// Holds the FSM state encoding, the 64-bit LFSR tap mask and the zero-seed substitute.
package puf_pkg;

    localparam int PUF_CHAL_W = 64;

    // Fibonacci taps 64,63,61,60 -> register bits 63,62,60,59
    localparam logic [PUF_CHAL_W-1:0] LFSR_TAPS     = 64'hD800_0000_0000_0000;
    localparam logic [PUF_CHAL_W-1:0] ZERO_SEED_SUB = 64'h0000_0000_0000_0001;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    function automatic logic [PUF_CHAL_W-1:0] lfsr_step(input logic [PUF_CHAL_W-1:0] c);
        return {c[PUF_CHAL_W-2:0], ^(c & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/puf_chal_lfsr.sv
// Challenge register: loads the seed (zero replaced so the LFSR cannot lock) or steps the LFSR.
// Latency: one cycle from load/step to the new challenge. No backpressure; load has priority.
module puf_chal_lfsr
    import puf_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic [PUF_CHAL_W-1:0] seed,
    output logic [PUF_CHAL_W-1:0] chal
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chal <= '0;
        end else if (load) begin
            chal <= (seed == '0) ? ZERO_SEED_SUB : seed;
        end else if (step) begin
            chal <= lfsr_step(chal);
        end
    end

endmodule

// File: rtl/puf_crp_sequencer.sv
// Runs one arbiter-PUF evaluation: excite, settle, sample, step LFSR, per response bit.
// Latency: done RESP_BITS*(SETTLE_CYCLES+2)+1 cycles after start (x3 passes with PUF_MAJORITY_VOTE_EN).
// No backpressure: start is only honoured in IDLE and is never queued while busy.
module puf_crp_sequencer
    import puf_pkg::*;
#(
    parameter int RESP_BITS     = 64,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [PUF_CHAL_W-1:0] challenge_in,
    input  logic                  puf_resp,
    output logic [PUF_CHAL_W-1:0] puf_challenge,
    output logic                  puf_excite,
    output logic                  busy,
    output logic                  done,
    output logic [63:0]           response,
    output logic [6:0]            bit_count
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    state_t         state, state_nxt;
    logic [SW-1:0]  settle_cnt;
    logic           load, step;
    logic           settle_done, bit_last, last_pass, resp_bit;

    assign settle_done = (settle_cnt == SW'(SETTLE_CYCLES - 1));
    assign bit_last    = (bit_count == 7'(RESP_BITS - 1));

`ifdef PUF_MAJORITY_VOTE_EN
    logic [1:0] vote_cnt, pass_cnt, votes_now;

    // Include the current sample so the third pass can decide in the same cycle
    assign votes_now = vote_cnt + {1'b0, puf_resp};
    assign last_pass = (pass_cnt == 2'd2);
    assign resp_bit  = (votes_now >= 2'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vote_cnt <= '0;
            pass_cnt <= '0;
        end else if (load || (state == SAMPLE && last_pass)) begin
            vote_cnt <= '0;
            pass_cnt <= '0;
        end else if (state == SAMPLE) begin
            vote_cnt <= votes_now;
            pass_cnt <= pass_cnt + 2'd1;
        end
    end
`else
    assign last_pass = 1'b1;
    assign resp_bit  = puf_resp;
`endif

    always_comb begin
        state_nxt  = state;
        load       = 1'b0;
        step       = 1'b0;
        puf_excite = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = APPLY;
                end
            end
            APPLY: begin
                puf_excite = 1'b1;
                busy       = 1'b1;
                state_nxt  = SETTLE;
            end
            SETTLE: begin
                busy = 1'b1;
                if (settle_done) state_nxt = SAMPLE;
            end
            SAMPLE: begin
                busy = 1'b1;
                if (last_pass) begin
                    step      = 1'b1;
                    state_nxt = bit_last ? DONE : APPLY;
                end else begin
                    state_nxt = APPLY;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            response   <= '0;
            bit_count  <= '0;
        end else begin
            state <= state_nxt;
            if (state == SETTLE && !settle_done) settle_cnt <= settle_cnt + SW'(1);
            else                                 settle_cnt <= '0;
            if (load) begin
                response  <= '0;
                bit_count <= '0;
            end else if (state == SAMPLE && last_pass) begin
                response  <= {response[62:0], resp_bit};
                bit_count <= bit_count + 7'd1;
            end
        end
    end

    puf_chal_lfsr u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .step (step),
        .seed (challenge_in),
        .chal (puf_challenge)
    );

endmodule
